// File: rtl/profile_trace_ci.sv
// Windowed stall/bus-idle trace sampler on the custom-instruction bus.
// One packed {stall, idle} sample per window is queued in a FIFO for the CPU to pop.
module profile_trace_ci #(
    parameter logic [7:0]  customId      = 8'h00,
    parameter int unsigned fifoDepthLog2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic        stall,
    input  logic        busIdle,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned Depth = 1 << fifoDepthLog2;
    localparam int unsigned PtrW  = fifoDepthLog2;
    localparam int unsigned FillW = fifoDepthLog2 + 1;

    localparam logic [2:0] OpConfig = 3'd0;
    localparam logic [2:0] OpPop    = 3'd1;
    localparam logic [2:0] OpStatus = 3'd2;
    localparam logic [2:0] OpClear  = 3'd3;

    logic             en_q, en_d;
    logic [15:0]      win_len_q, win_len_d;
    logic [15:0]      win_cnt_q, win_cnt_d;
    logic [15:0]      stall_acc_q, stall_acc_d;
    logic [15:0]      idle_acc_q, idle_acc_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [31:0]      mem_q [Depth];

    logic        sel, is_cfg, is_pop, is_clr;
    logic [2:0]  op;
    logic        active, win_end, empty, full;
    logic        pop, push_req, push, drop;
    logic [15:0] stall_nxt, idle_nxt;
    logic        unused_bits;

    assign unused_bits = ^{valueA[31:3], valueB[31:17]};

    assign op     = valueA[2:0];
    assign sel    = start & (ciN == customId);
    assign is_cfg = sel & (op == OpConfig);
    assign is_pop = sel & (op == OpPop);
    assign is_clr = sel & (op == OpClear);

    assign active    = en_q & (win_len_q != 16'd0);
    assign win_end   = active & (win_cnt_q == win_len_q - 16'd1);
    assign stall_nxt = stall_acc_q + {15'd0, stall};
    assign idle_nxt  = idle_acc_q + {15'd0, busIdle};

    assign empty = (fill_q == '0);
    assign full  = (fill_q == FillW'(Depth));
    assign pop   = is_pop & ~empty;

    // CONFIG/CLEAR landing on a window end discard that sample outright.
    assign push_req = win_end & ~is_cfg & ~is_clr;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        en_d        = en_q;
        win_len_d   = win_len_q;
        win_cnt_d   = 16'd0;
        stall_acc_d = 16'd0;
        idle_acc_d  = 16'd0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        drop_cnt_d  = drop_cnt_q;

        if (active && !win_end) begin
            win_cnt_d   = win_cnt_q + 16'd1;
            stall_acc_d = stall_nxt;
            idle_acc_d  = idle_nxt;
        end

        if (is_cfg) begin
            win_len_d   = valueB[15:0];
            en_d        = valueB[16];
            win_cnt_d   = 16'd0;
            stall_acc_d = 16'd0;
            idle_acc_d  = 16'd0;
        end

        if (is_clr) begin
            win_cnt_d   = 16'd0;
            stall_acc_d = 16'd0;
            idle_acc_d  = 16'd0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fill_d      = '0;
            drop_cnt_d  = 16'd0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            fill_d = fill_q + FillW'(push) - FillW'(pop);
            if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_q        <= 1'b0;
            win_len_q   <= 16'd0;
            win_cnt_q   <= 16'd0;
            stall_acc_q <= 16'd0;
            idle_acc_q  <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            drop_cnt_q  <= 16'd0;
        end else begin
            en_q        <= en_d;
            win_len_q   <= win_len_d;
            win_cnt_q   <= win_cnt_d;
            stall_acc_q <= stall_acc_d;
            idle_acc_q  <= idle_acc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Sample storage carries no reset; contents are qualified by fill.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {stall_nxt, idle_nxt};
    end

    assign done = sel;

    always_comb begin
        result = 32'd0;
        if (sel) begin
            case (op)
                OpPop:    if (!empty) result = mem_q[rd_ptr_q];
                OpStatus: result = {drop_cnt_q, 5'd0, active, full, empty, 8'(fill_q)};
                default:  result = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_profile_trace_ci.sv
// Self-checking bench for profile_trace_ci: opcode vector table plus
// cycle-exact window sequences, compared through an expectation queue.
module tb_profile_trace_ci;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] valueA = 32'd0;
    logic [31:0] valueB = 32'd0;
    logic        stall = 1'b0;
    logic        busIdle = 1'b0;
    logic        done;
    logic [31:0] result;

    localparam logic [7:0] MyId    = 8'h00;
    localparam logic [7:0] OtherId = 8'h05;

    profile_trace_ci dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .ciN     (ciN),
        .valueA  (valueA),
        .valueB  (valueB),
        .stall   (stall),
        .busIdle (busIdle),
        .done    (done),
        .result  (result)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        exp_done;
        logic [31:0] exp_res;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string       name;
        logic [7:0]  id;
        logic [2:0]  op;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One instruction cycle: drive at negedge, sample mid-cycle, consume one posedge.
    task automatic ci(input string name, input logic [7:0] id, input logic [2:0] op,
                      input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        @(negedge clock);
        start  = 1'b1;
        ciN    = id;
        valueA = {29'd0, op};
        valueB = b;
        sb.push_back('{name, (id == MyId), exp});
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h, expected an entry", name, result);
        end else begin
            e = sb.pop_front();
            check({e.name, " done"}, {31'd0, done}, {31'd0, e.exp_done});
            check({e.name, " result"}, result, e.exp_res);
        end
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic cyc(input logic st, input logic bi);
        @(negedge clock);
        start   = 1'b0;
        stall   = st;
        busIdle = bi;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        stall   = 1'b0;
        busIdle = 1'b0;
        #1;
        check("idle done", {31'd0, done}, 32'd0);
        check("idle result", result, 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        tbl[0] = '{"status after reset", MyId,    3'd2, 32'd0,          32'h0000_0100};
        tbl[1] = '{"pop empty",          MyId,    3'd1, 32'd0,          32'h0000_0000};
        tbl[2] = '{"status after pop",   MyId,    3'd2, 32'd0,          32'h0000_0100};
        tbl[3] = '{"op4 noop",           MyId,    3'd4, 32'hFFFF_FFFF,  32'h0000_0000};
        tbl[4] = '{"op7 noop",           MyId,    3'd7, 32'hFFFF_FFFF,  32'h0000_0000};
        tbl[5] = '{"foreign config",     OtherId, 3'd0, 32'h0001_0004,  32'h0000_0000};
        tbl[6] = '{"foreign status",     OtherId, 3'd2, 32'd0,          32'h0000_0000};
        tbl[7] = '{"status still idle",  MyId,    3'd2, 32'd0,          32'h0000_0100};

        do_reset();
        foreach (tbl[i]) ci(tbl[i].name, tbl[i].id, tbl[i].op, tbl[i].b, tbl[i].exp);

        // Window of 8 with stall held high.
        do_reset();
        ci("cfg w8", MyId, 3'd0, 32'h0001_0008, 32'd0);
        repeat (8) cyc(1'b1, 1'b0);
        ci("w8 status", MyId, 3'd2, 32'd0, 32'h0000_0401);
        ci("w8 pop", MyId, 3'd1, 32'd0, 32'h0008_0000);
        ci("w8 status empty", MyId, 3'd2, 32'd0, 32'h0000_0500);

        // Window of 4, busIdle high, stall toggling.
        do_reset();
        ci("cfg w4 toggle", MyId, 3'd0, 32'h0001_0004, 32'd0);
        for (int w = 0; w < 3; w++)
            for (int c = 0; c < 4; c++) cyc((c % 2) == 0, 1'b1);
        ci("toggle status", MyId, 3'd2, 32'd0, 32'h0000_0403);
        for (int k = 0; k < 3; k++) ci("toggle pop", MyId, 3'd1, 32'd0, 32'h0002_0004);

        // Overflow: 20 windows into 16 slots, then pop on a window end.
        do_reset();
        ci("cfg w4 fill", MyId, 3'd0, 32'h0001_0004, 32'd0);
        repeat (80) cyc(1'b0, 1'b1);
        ci("full status", MyId, 3'd2, 32'd0, 32'h0004_0610);
        repeat (2) cyc(1'b0, 1'b1);
        ci("pop on window end", MyId, 3'd1, 32'd0, 32'h0000_0004);
        ci("full status after pop+push", MyId, 3'd2, 32'd0, 32'h0004_0610);
        ci("pop mid window", MyId, 3'd1, 32'd0, 32'h0000_0004);
        ci("status fill 15", MyId, 3'd2, 32'd0, 32'h0004_040F);
        ci("clear on window end", MyId, 3'd3, 32'd0, 32'd0);
        ci("status after clear", MyId, 3'd2, 32'd0, 32'h0000_0500);
        repeat (2) cyc(1'b0, 1'b1);
        ci("pop empty on window end", MyId, 3'd1, 32'd0, 32'd0);
        ci("status push into empty", MyId, 3'd2, 32'd0, 32'h0000_0401);

        // CLEAR on a window end with three entries queued.
        do_reset();
        ci("cfg w4 clear", MyId, 3'd0, 32'h0001_0004, 32'd0);
        repeat (12) cyc(1'b0, 1'b1);
        ci("three queued", MyId, 3'd2, 32'd0, 32'h0000_0403);
        repeat (2) cyc(1'b0, 1'b1);
        ci("clear at end", MyId, 3'd3, 32'd0, 32'd0);
        ci("cleared status", MyId, 3'd2, 32'd0, 32'h0000_0500);
        repeat (2) cyc(1'b0, 1'b1);
        ci("no entry before winLen", MyId, 3'd2, 32'd0, 32'h0000_0500);
        ci("entry after winLen", MyId, 3'd2, 32'd0, 32'h0000_0401);
        ci("pop after clear", MyId, 3'd1, 32'd0, 32'h0000_0004);

        // Foreign CLEAR is ignored; reset mid-window wipes everything.
        do_reset();
        ci("cfg w2", MyId, 3'd0, 32'h0001_0002, 32'd0);
        repeat (4) cyc(1'b0, 1'b1);
        ci("foreign clear", OtherId, 3'd3, 32'd0, 32'd0);
        ci("status after foreign", MyId, 3'd2, 32'd0, 32'h0000_0402);
        do_reset();
        ci("status after reset mid-window", MyId, 3'd2, 32'd0, 32'h0000_0100);
        repeat (4) cyc(1'b0, 1'b1);
        ci("status stays disabled", MyId, 3'd2, 32'd0, 32'h0000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
